fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined MIPS core.
- Owns the PC register and next-PC selection, drives the address into the combinational 64-word instruction memory, and registers the returned word into the IF/ID pipeline register.
- Accepts stall from the hazard unit and redirect (branch/jump) from ID.
- Halts cleanly when the PC leaves the populated memory range.

---
 rtl/pipe_pkg.sv | 26 ++
 rtl/if_id_reg.sv | 42 ++++
 rtl/fetch_stage.sv | 134 +++++++++++++
 tb/tb_fetch_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: PC width, bubble word, fetch FSM states and
// the IF/ID bundle that later pipeline registers reuse.
package pipe_pkg;

  localparam int PC_W = 32;

  // Bubble word used on flush and halt (sll $0,$0,0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // Force a byte address onto a word boundary.
  function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold and flush. Hold wins over flush, so a
// stalled stage never loses the instruction it is holding.
module if_id_reg
  import pipe_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = pipe_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t bundle_q;
  if_id_t bubble_s;

  // Bubble contents loaded on reset and on flush.
  always_comb begin
    bubble_s          = '0;
    bubble_s.instr    = NOP_WORD;
    bubble_s.pc_plus4 = 32'h0000_0000;
    bubble_s.valid    = 1'b0;
  end

  // Pipeline register: hold, else flush to a bubble, else load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bundle_q <= bubble_s;
    end else if (hold_i) begin
      bundle_q <= bundle_q;
    end else if (flush_i) begin
      bundle_q <= bubble_s;
    end else begin
      bundle_q <= d_i;
    end
  end

  assign q_o = bundle_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, halt on leaving
// the populated instruction memory, and the IF/ID register toward decode.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64,
  parameter int          CNT_W      = 16,
  parameter logic [31:0] NOP_INSTR  = pipe_pkg::NOP_INSTR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_instr,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc_plus4,
  output logic             if_id_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [PC_W-1:0]  IMEM_BYTES = 32'(IMEM_WORDS * 4);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [PC_W-1:0]  pc_plus4_s;
  logic             oob_s;
  logic             hold_s;
  logic             flush_s;
  if_id_t           if_d_s;
  if_id_t           if_q_s;

  // Next-PC selection and fetch FSM transitions; the first matching rule wins.
  always_comb begin
    pc_plus4_s = pc_q + 32'd4;
    oob_s      = (pc_q >= IMEM_BYTES);
    pc_d       = pc_q;
    state_d    = state_q;
    halted_d   = halted_q;
    cnt_d      = cnt_q;
    hold_s     = 1'b1;
    flush_s    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (stall) begin
          // Redirects seen during a stall are re-presented afterwards.
          hold_s = 1'b1;
        end else if (branch_taken) begin
          pc_d    = align_word(branch_target);
          hold_s  = 1'b0;
          flush_s = 1'b1;
        end else if (jump) begin
          pc_d    = align_word(jump_target);
          hold_s  = 1'b0;
          flush_s = 1'b1;
        end else if (oob_s) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
          hold_s   = 1'b0;
          flush_s  = 1'b1;
        end else begin
          pc_d    = pc_plus4_s;
          hold_s  = 1'b0;
          flush_s = 1'b0;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
        end
      end
      ST_HALT: begin
        // Only reset leaves HALT; the bubble in IF/ID stays put.
        hold_s   = 1'b1;
        halted_d = 1'b1;
      end
      default: begin
        // Corrupted state: stop fetching and present a bubble.
        state_d  = ST_HALT;
        halted_d = 1'b1;
        hold_s   = 1'b0;
        flush_s  = 1'b1;
      end
    endcase
  end

  // Bundle offered to IF/ID when a sequential fetch completes.
  always_comb begin
    if_d_s          = '0;
    if_d_s.instr    = imem_instr;
    if_d_s.pc_plus4 = pc_plus4_s;
    if_d_s.valid    = 1'b1;
  end

  // FSM state, PC, halt flag and fetch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      pc_q     <= align_word(RESET_PC);
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      cnt_q    <= cnt_d;
    end
  end

  if_id_reg #(
    .NOP_WORD (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold_i  (hold_s),
    .flush_i (flush_s),
    .d_i     (if_d_s),
    .q_o     (if_q_s)
  );

  assign imem_addr      = pc_q;
  assign if_id_instr    = if_q_s.instr;
  assign if_id_pc_plus4 = if_q_s.pc_plus4;
  assign if_id_valid    = if_q_s.valid;
  assign halted         = halted_q;
  assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 64-word behavioural instruction memory.
module tb_fetch_stage;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             stall;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump;
  logic [31:0]      jump_target;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_instr;
  logic [31:0]      if_id_instr;
  logic [31:0]      if_id_pc_plus4;
  logic             if_id_valid;
  logic             halted;
  logic [CNT_W-1:0] fetch_count;

  logic [31:0] mem [0:63];
  int n_vec;
  int n_err;

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (64),
    .CNT_W      (CNT_W),
    .NOP_INSTR  (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  // Combinational instruction memory; out-of-range reads return a marker.
  assign imem_instr = (imem_addr < 32'd256) ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] instr,
                          input logic [31:0] pc4, input logic valid);
    chk({tag, ".instr"}, if_id_instr, instr);
    chk({tag, ".pc4"}, if_id_pc_plus4, pc4);
    chk({tag, ".valid"}, 32'(if_id_valid), 32'(valid));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    for (int i = 2; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);

    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst.pc", imem_addr, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    chk("rst.halted", 32'(halted), 32'h0);
    chk("rst.cnt", 32'(fetch_count), 32'h0);
    rst_n = 1'b1;

    // Two sequential fetches
    tick();
    chk_ifid("c1", 32'h2008_0005, 32'h4, 1'b1);
    chk("c1.pc", imem_addr, 32'h4);
    tick();
    chk_ifid("c2", 32'h2009_0003, 32'h8, 1'b1);
    chk("c2.cnt", 32'(fetch_count), 32'h2);

    // Stall for 3 edges at pc=8
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall.pc", imem_addr, 32'h8);
      chk_ifid("stall", 32'h2009_0003, 32'h8, 1'b1);
      chk("stall.cnt", 32'(fetch_count), 32'h2);
    end
    stall = 1'b0;
    tick();
    chk_ifid("unstall", 32'h1000_0002, 32'hC, 1'b1);
    chk("unstall.cnt", 32'(fetch_count), 32'h3);
    tick();
    chk("seq.pc16", imem_addr, 32'h10);

    // Branch with misaligned target at pc=16
    branch_taken = 1'b1; branch_target = 32'h0000_0013;
    tick();
    branch_taken = 1'b0;
    chk("br.pc", imem_addr, 32'h10);
    chk("br.valid", 32'(if_id_valid), 32'h0);
    chk("br.instr", if_id_instr, 32'h0);
    chk("br.cnt", 32'(fetch_count), 32'h4);
    tick();
    chk_ifid("br.refetch", 32'h1000_0004, 32'h14, 1'b1);

    // Branch beats jump
    branch_taken = 1'b1; jump = 1'b1; jump_target = 32'h20;
    tick();
    branch_taken = 1'b0; jump = 1'b0;
    chk("brj.pc", imem_addr, 32'h10);
    chk("brj.valid", 32'(if_id_valid), 32'h0);

    // Stall masks a jump; jump taken once stall drops
    stall = 1'b1; jump = 1'b1; jump_target = 32'h20;
    tick();
    chk("stj.pc", imem_addr, 32'h10);
    stall = 1'b0;
    tick();
    jump = 1'b0;
    chk("j.pc", imem_addr, 32'h20);
    chk("j.valid", 32'(if_id_valid), 32'h0);
    chk("j.cnt", 32'(fetch_count), 32'h5);

    // Sequential run through words 8..63; counter saturates at 15
    for (int k = 0; k < 56; k++) begin
      tick();
      chk("run.instr", if_id_instr, mem[8 + k]);
      chk("run.pc", imem_addr, 32'((9 + k) * 4));
      chk("run.cnt", 32'(fetch_count), (6 + k > 15) ? 32'd15 : 32'(6 + k));
    end
    chk("run.end.pc4", if_id_pc_plus4, 32'h100);

    // pc=256 is out of range: halt on the next edge
    tick();
    chk("oob.halted", 32'(halted), 32'h1);
    chk("oob.valid", 32'(if_id_valid), 32'h0);
    chk("oob.instr", if_id_instr, 32'h0);
    chk("oob.pc", imem_addr, 32'h100);

    // Redirects ignored in HALT
    jump = 1'b1; jump_target = 32'h0; branch_taken = 1'b1; branch_target = 32'h4;
    repeat (2) tick();
    jump = 1'b0; branch_taken = 1'b0;
    chk("halt.pc", imem_addr, 32'h100);
    chk("halt.halted", 32'(halted), 32'h1);
    chk("halt.valid", 32'(if_id_valid), 32'h0);
    chk("halt.cnt", 32'(fetch_count), 32'd15);

    // Reset exits HALT
    rst_n = 1'b0;
    #1;
    chk("hrst.pc", imem_addr, 32'h0);
    chk("hrst.halted", 32'(halted), 32'h0);
    chk("hrst.cnt", 32'(fetch_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset between edges while IF/ID is valid
    repeat (2) tick();
    chk("pre.valid", 32'(if_id_valid), 32'h1);
    chk("pre.pc", imem_addr, 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk_ifid("arst", 32'h0, 32'h0, 1'b0);
    chk("arst.pc", imem_addr, 32'h0);
    chk("arst.cnt", 32'(fetch_count), 32'h0);
    chk("arst.halted", 32'(halted), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_ifid("post", 32'h2008_0005, 32'h4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
